led_fade_driver: RTL and testbench

Output stage between the LED pattern sequencer and the board LED pins. Takes the sequencer's 8-bit on/off pattern and drives each LED with a per-channel PWM brightness level. A channel jumps to full brightness when its pattern bit is high and decays linearly once the bit drops, so discrete pattern steps become visible trailing fades. The free-running PWM counter and fade prescaler live inside this block.

---
 rtl/led_pkg.sv | 9 +
 rtl/led_pwm_channel.sv | 59 +++++
 rtl/led_fade_driver.sv | 55 +++++
 tb/tb_led_fade_driver.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern sequencer and the LED fade output stage.
package led_pkg;

    localparam int LED_COUNT = 8;
    localparam int PWM_BITS  = 8;

    typedef logic [PWM_BITS-1:0] pwm_level_t;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: brightness level with jump-to-MAX / linear decay and a registered PWM compare.
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS  = 8,
    parameter int FADE_STEP = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pattern_bit,
    input  logic                fade_en,
    input  logic                fade_tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led_bit
);

    localparam logic [PWM_BITS-1:0] LVL_MAX  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] LVL_ZERO = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] STEP     = PWM_BITS'(FADE_STEP);

    // Saturating subtract: a level at or below the step lands on zero instead of wrapping.
    function automatic logic [PWM_BITS-1:0] sat_sub(input logic [PWM_BITS-1:0] a,
                                                    input logic [PWM_BITS-1:0] b);
        if (a > b) begin
            return a - b;
        end else begin
            return LVL_ZERO;
        end
    endfunction

    logic [PWM_BITS-1:0] r_level;
    logic [PWM_BITS-1:0] w_level_nxt;

    // Next level, highest priority first: pattern, bypass, decay tick, hold.
    always_comb begin
        w_level_nxt = r_level;
        if (pattern_bit) begin
            w_level_nxt = LVL_MAX;
        end else if (!fade_en) begin
            w_level_nxt = LVL_ZERO;
        end else if (fade_tick && (r_level != LVL_ZERO)) begin
            w_level_nxt = sat_sub(r_level, STEP);
        end else begin
            w_level_nxt = r_level;
        end
    end

    // Level register and PWM compare flop; MAX is forced solid on.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= LVL_ZERO;
            led_bit <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            led_bit <= (r_level == LVL_MAX) || (r_level > pwm_cnt);
        end
    end

endmodule

// File: rtl/led_fade_driver.sv
// LED output stage: shared PWM counter and fade prescaler feeding eight independent fade channels.
module led_fade_driver
    import led_pkg::*;
#(
    parameter int PWM_BITS  = led_pkg::PWM_BITS,
    parameter int FADE_DIV  = 500000,
    parameter int FADE_STEP = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [LED_COUNT-1:0] pattern,
    input  logic                 fade_en,
    output logic [LED_COUNT-1:0] led
);

    localparam int                  FADE_CNT_W = $clog2(FADE_DIV);
    localparam logic [FADE_CNT_W-1:0] FADE_LAST = FADE_CNT_W'(FADE_DIV - 1);

    logic [PWM_BITS-1:0]   r_pwm_cnt;
    logic [FADE_CNT_W-1:0] r_fade_cnt;
    logic                  w_fade_tick;

    assign w_fade_tick = (r_fade_cnt == FADE_LAST);

    // Free-running PWM counter and fade prescaler.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm_cnt  <= {PWM_BITS{1'b0}};
            r_fade_cnt <= {FADE_CNT_W{1'b0}};
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            if (w_fade_tick) begin
                r_fade_cnt <= {FADE_CNT_W{1'b0}};
            end else begin
                r_fade_cnt <= r_fade_cnt + FADE_CNT_W'(1);
            end
        end
    end

    for (genvar gi = 0; gi < LED_COUNT; gi++) begin : g_ch
        led_pwm_channel #(
            .PWM_BITS  (PWM_BITS),
            .FADE_STEP (FADE_STEP)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .pattern_bit (pattern[gi]),
            .fade_en     (fade_en),
            .fade_tick   (w_fade_tick),
            .pwm_cnt     (r_pwm_cnt),
            .led_bit     (led[gi])
        );
    end

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver: vector table for reset/bypass, hand sequences for fades.
module tb_led_fade_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] pattern = 8'h00;
    logic       fade_en = 1'b1;
    logic [7:0] led;
    logic [7:0] led_s255;
    logic [7:0] led_slow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    led_fade_driver #(.PWM_BITS(8), .FADE_DIV(4), .FADE_STEP(64)) dut (
        .clk(clk), .reset(reset), .pattern(pattern), .fade_en(fade_en), .led(led)
    );

    led_fade_driver #(.PWM_BITS(8), .FADE_DIV(4), .FADE_STEP(255)) dut_s255 (
        .clk(clk), .reset(reset), .pattern(pattern), .fade_en(fade_en), .led(led_s255)
    );

    led_fade_driver #(.PWM_BITS(8), .FADE_DIV(1024), .FADE_STEP(64)) dut_slow (
        .clk(clk), .reset(reset), .pattern(pattern), .fade_en(fade_en), .led(led_slow)
    );

    typedef struct {
        logic       rst;
        logic       fen;
        logic [7:0] pat;
        logic [7:0] exp_led;
    } vec_t;

    vec_t vecs [16];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // One reset edge (cyc 0 afterwards), then release; pat/fen already applied.
    task automatic do_reset(input logic [7:0] pat, input logic fen);
        reset   = 1'b1;
        pattern = pat;
        fade_en = fen;
        tick();
        cyc   = 0;
        reset = 1'b0;
    endtask

    initial begin
        int cnt;
        int exp_duty [4];

        vecs[0]  = '{1'b1, 1'b1, 8'hFF, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 8'hFF, 8'h00};
        vecs[2]  = '{1'b1, 1'b1, 8'hFF, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 8'hFF, 8'h00};
        vecs[4]  = '{1'b0, 1'b1, 8'hFF, 8'hFF};
        vecs[5]  = '{1'b0, 1'b0, 8'hFF, 8'hFF};
        vecs[6]  = '{1'b0, 1'b0, 8'hA5, 8'hFF};
        vecs[7]  = '{1'b0, 1'b0, 8'hA5, 8'hA5};
        vecs[8]  = '{1'b0, 1'b0, 8'hA5, 8'hA5};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 8'hA5};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 8'h00};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 8'h00};
        vecs[12] = '{1'b0, 1'b0, 8'h3C, 8'h00};
        vecs[13] = '{1'b0, 1'b0, 8'h3C, 8'h3C};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 8'h3C};
        vecs[15] = '{1'b0, 1'b0, 8'h00, 8'h00};

        for (int i = 0; i < 16; i++) begin
            reset   = vecs[i].rst;
            fade_en = vecs[i].fen;
            pattern = vecs[i].pat;
            tick();
            check($sformatf("vec%0d_led", i), {24'd0, led}, {24'd0, vecs[i].exp_led});
        end

        // Solid FF after reset release, held over three PWM periods.
        do_reset(8'hFF, 1'b1);
        tick();
        tick();
        check("rst_release_led", {24'd0, led}, 32'hFF);
        cnt = 0;
        for (int i = 0; i < 768; i++) begin
            tick();
            if (led !== 8'hFF) cnt++;
        end
        check("solid_ff_glitches", cnt, 32'd0);

        // Linear fade of channel 0; ticks land on edges 4, 8, 12, ...
        do_reset(8'h00, 1'b1);
        pattern = 8'h01;
        repeat (10) tick();
        pattern = 8'h00;
        check("fade_start_lvl", {24'd0, dut.g_ch[0].u_ch.r_level}, 32'd255);
        tick();
        check("fade_hold_lvl", {24'd0, dut.g_ch[0].u_ch.r_level}, 32'd255);
        check("s255_hold_lvl", {24'd0, dut_s255.g_ch[0].u_ch.r_level}, 32'd255);
        tick();
        check("fade_lvl191", {24'd0, dut.g_ch[0].u_ch.r_level}, 32'd191);
        check("s255_one_tick", {24'd0, dut_s255.g_ch[0].u_ch.r_level}, 32'd0);
        check("others_off", {24'd0, led & 8'hFE}, 32'd0);
        repeat (4) tick();
        check("fade_lvl127", {24'd0, dut.g_ch[0].u_ch.r_level}, 32'd127);
        repeat (4) tick();
        check("fade_lvl63", {24'd0, dut.g_ch[0].u_ch.r_level}, 32'd63);
        repeat (4) tick();
        check("fade_sat_lvl0", {24'd0, dut.g_ch[0].u_ch.r_level}, 32'd0);
        tick();
        check("fade_led_off", {24'd0, led}, 32'd0);

        // Duty per 256-cycle window on the slow instance (ticks every 1024 cycles).
        exp_duty[0] = 191;
        exp_duty[1] = 127;
        exp_duty[2] = 63;
        exp_duty[3] = 0;
        for (int j = 1; j <= 4; j++) begin
            while (cyc < 1024 * j + 75) tick();
            cnt = 0;
            for (int k = 0; k < 256; k++) begin
                tick();
                if (led_slow[0] === 1'b1) cnt++;
                if (led_slow[7:1] !== 7'd0) cnt += 1000;
            end
            check($sformatf("duty_step%0d", j), cnt, exp_duty[j-1]);
        end

        // Re-raise on a tick edge mid-fade restarts at MAX.
        do_reset(8'h00, 1'b1);
        pattern = 8'h01;
        repeat (2) tick();
        pattern = 8'h00;
        repeat (6) tick();
        check("rr_setup_lvl127", {24'd0, dut.g_ch[0].u_ch.r_level}, 32'd127);
        repeat (3) tick();
        pattern = 8'h01;
        tick();
        check("rr_tick_lvl255", {24'd0, dut.g_ch[0].u_ch.r_level}, 32'd255);
        pattern = 8'h00;
        repeat (4) tick();
        check("rr_restart191", {24'd0, dut.g_ch[0].u_ch.r_level}, 32'd191);

        // Reset while every channel sits at 127.
        do_reset(8'h00, 1'b1);
        pattern = 8'hFF;
        repeat (2) tick();
        pattern = 8'h00;
        repeat (6) tick();
        check("mr_lvl127_ch7", {24'd0, dut.g_ch[7].u_ch.r_level}, 32'd127);
        tick();
        check("mr_led_pre", {24'd0, led}, 32'hFF);
        reset = 1'b1;
        tick();
        check("mr_led_reset", {24'd0, led}, 32'h00);
        reset = 1'b0;
        tick();
        check("mr_lvl0_ch0", {24'd0, dut.g_ch[0].u_ch.r_level}, 32'd0);
        check("mr_lvl0_ch7", {24'd0, dut.g_ch[7].u_ch.r_level}, 32'd0);
        cnt = 0;
        repeat (8) begin
            tick();
            if (led !== 8'h00) cnt++;
        end
        check("mr_led_stays_off", cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
